hyperbus_trans_engine: RTL and testbench
========================================

// Module: hyperbus_trans_engine
// PURPOSE
// Executes one HyperBus transaction at a time on behalf of the AXI front-end.
// - Accepts a command on the trans_* handshake.
// - Builds the 48-bit command-address (CA) and sends it as three 16-bit words.
// - Waits out the initial latency, then streams write data or collects read data.
// - Returns read beats (rx_*) and write responses (b_*) to the front-end.
// Sits between the AXI front-end and the word-level DDR PHY (phy_*).
// PARAMETERS
// AddrWidth     32  byte address width of trans_address_i (MSB = address space)
// NumChipSel    2   number of chip selects
// LatencyCycles 6   initial-latency word slots between CA and data
// CsRecovery    2   cycles all CS stay high between transactions
// ReadTimeout   64  cycles without phy_rx_valid_i before a read aborts
// PORTS
// clk_i                  in  1           clock
// rst_ni                 in  1           async reset, active low
// trans_valid_i          in  1           command valid
// trans_ready_o          out 1           command accepted
// trans_address_i        in  AddrWidth   byte address
// trans_cs_i             in  NumChipSel  one-hot chip select
// trans_write_i          in  1           1 = write
// trans_burst_i          in  8           beats-1 (AXI len)
// trans_burst_type_i     in  1           1 = linear (INCR), 0 = wrapped
// trans_address_space_i  in  1           1 = register space
// tx_data_i/tx_strb_i    in  16/2        write beat, byte strobes
// tx_valid_i             in  1           write beat valid
// tx_ready_o             out 1           write beat accepted
// rx_data_o              out 16          read beat data
// rx_last_o              out 1           final read beat
// rx_error_o             out 1           read beat error
// rx_valid_o             out 1           read beat valid
// rx_ready_i             in  1           read beat accepted
// b_valid_o              out 1           write response valid
// b_ready_i              in  1           write response accepted
// b_last_o               out 1           write response last
// b_error_o              out 1           write response error
// phy_cs_no              out NumChipSel  active-low chip selects
// phy_oe_o               out 1           controller drives DQ
// phy_word_o             out 16          word to PHY
// phy_mask_o             out 2           RWDS mask, 1 = byte masked
// phy_word_valid_o       out 1           word to PHY valid
// phy_word_ready_i       in  1           PHY accepts word / latency slot
// phy_rx_word_i          in  16          word from PHY
// phy_rx_valid_i         in  1           word from PHY valid
// phy_rx_ready_o         out 1           = rx_ready_i while in READ, else 0
// BEHAVIOUR
// - Reset values: phy_cs_no all 1s; every other output 0 except trans_ready_o = 1 (state IDLE).
// - Reset mid-transaction aborts immediately. No response is generated for the aborted transaction.
// - FSM: IDLE -> CA -> LAT -> {WDATA | RDATA} -> (write: RESP) -> RECOV -> IDLE.
// - IDLE: trans_ready_o = 1. On trans_valid_i, register all trans_* fields and move to CA next cycle.
// - CA construction, word address wa = trans_address_i[AddrWidth-2:1]:
//   - CA[47] = ~write, CA[46] = address space, CA[45] = burst type.
//   - CA[44:16] = wa[31:3] (zero-extended); CA[15:3] = 0; CA[2:0] = wa[2:0].
// - CA state:
//   - Send CA[47:32], CA[31:16], CA[15:0], one per phy handshake, with phy_oe_o = 1 and mask = 0.
//   - phy_cs_no = ~cs from the first CA word until leaving WDATA/RDATA.
// - LAT state:
//   - Count LatencyCycles cycles in which phy_word_ready_i = 1; phy_word_valid_o = 0.
//   - Skipped entirely for register-space writes (zero latency).
// - WDATA state:
//   - Pass-through: phy_word_o = tx_data_i, phy_mask_o = ~tx_strb_i, phy_word_valid_o = tx_valid_i, tx_ready_o = phy_word_ready_i.
//   - Ends after trans_burst_i+1 beats.
//   - Register write with burst != 0: forward only the first beat, drain the rest with phy_word_valid_o = 0, respond with b_error_o = 1.
// - RESP state: b_valid_o = b_last_o = 1 until b_ready_i; b_error_o as above.
// - RDATA state:
//   - rx_data_o = phy_rx_word_i, rx_valid_o = phy_rx_valid_i; rx_last_o on beat trans_burst_i+1.
//   - ReadTimeout consecutive cycles without phy_rx_valid_i: release CS, then emit the remaining beats internally with data 0, rx_error_o = 1, and correct rx_last_o.
// - RECOV state: CsRecovery cycles with all CS high; then IDLE.
// - Beat counter is 9 bits, so trans_burst_i = 255 gives 256 beats with no wrap.
// - trans_cs_i == 0: no bus access (CS stay high).
//   - Write: drain beats, b_error_o = 1.
//   - Read: burst+1 error beats.
// TESTING
// - Read, addr 0x0000_0010, burst 3, INCR:
//   - CA words 0xA000, 0x0001, 0x0000; then 6 latency slots; 4 beats, rx_last_o on beat 4.
// - Write, addr 0x20, burst 1, strb 2'b01 then 2'b11:
//   - Masks 2'b10, 2'b00; then b_valid_o with b_error_o = 0.
// - Register write, address space = 1, burst 0:
//   - CA[47:46] = 2'b01, no latency slots, data word directly after CA.
// - Register write with burst 2 -> one word sent, 3 tx beats consumed, b_error_o = 1.
// - Read with phy_rx_valid_i held 0 for 64 cycles after 1 beat:
//   - CS deasserts; beats 2..N return rx_error_o = 1; last beat flagged.
// - rst_ni pulsed during WDATA -> CS all high the same cycle, no b_valid_o, next command accepted normally.

Source files
------------

// File: rtl/hyperbus_trans_engine.sv
`default_nettype none
// ============================================================================
// Module      : hyperbus_trans_engine
// Description : Runs one HyperBus transaction at a time for the AXI
//               front-end. It builds and sends the 48-bit command-address
//               (CA), waits out the initial latency, then either streams
//               write beats to the PHY or returns read beats. Write
//               transactions end with a single response.
// Ports       : clk_i / rst_ni         clock, async active-low reset
//               trans_*                command handshake and fields
//               tx_*                   write beats from the front-end
//               rx_*                   read beats to the front-end
//               b_*                    write response to the front-end
//               phy_*                  word-level DDR PHY interface
// Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_trans_engine #(
   parameter int ADDR_WIDTH     = 32,
   parameter int NUM_CHIP_SEL   = 2,
   parameter int LATENCY_CYCLES = 6,
   parameter int CS_RECOVERY    = 2,
   parameter int READ_TIMEOUT   = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    trans_valid_i,
   output logic                    trans_ready_o,
   input  logic [ADDR_WIDTH-1:0]   trans_address_i,
   input  logic [NUM_CHIP_SEL-1:0] trans_cs_i,
   input  logic                    trans_write_i,
   input  logic [7:0]              trans_burst_i,
   input  logic                    trans_burst_type_i,
   input  logic                    trans_address_space_i,
   input  logic [15:0]             tx_data_i,
   input  logic [1:0]              tx_strb_i,
   input  logic                    tx_valid_i,
   output logic                    tx_ready_o,
   output logic [15:0]             rx_data_o,
   output logic                    rx_last_o,
   output logic                    rx_error_o,
   output logic                    rx_valid_o,
   input  logic                    rx_ready_i,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   output logic                    b_last_o,
   output logic                    b_error_o,
   output logic [NUM_CHIP_SEL-1:0] phy_cs_no,
   output logic                    phy_oe_o,
   output logic [15:0]             phy_word_o,
   output logic [1:0]              phy_mask_o,
   output logic                    phy_word_valid_o,
   input  logic                    phy_word_ready_i,
   input  logic [15:0]             phy_rx_word_i,
   input  logic                    phy_rx_valid_i,
   output logic                    phy_rx_ready_o
);

   localparam int c_WA_W  = ADDR_WIDTH - 2;
   localparam int c_LAT_W = $clog2(LATENCY_CYCLES + 1);
   localparam int c_TO_W  = $clog2(READ_TIMEOUT + 1);
   localparam int c_REC_W = $clog2(CS_RECOVERY + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CA    = 3'd1,
      S_LAT   = 3'd2,
      S_WDATA = 3'd3,
      S_RDATA = 3'd4,
      S_RESP  = 3'd5,
      S_RECOV = 3'd6
   } state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [c_WA_W-1:0]       r_wa;
   logic [NUM_CHIP_SEL-1:0] r_cs;
   logic                    r_write;
   logic [7:0]              r_burst;
   logic                    r_btype;
   logic                    r_aspace;
   logic [1:0]              r_ca_cnt;
   logic [c_LAT_W-1:0]      r_lat_cnt;
   logic [8:0]              r_beat_cnt;
   logic [c_TO_W-1:0]       r_to_cnt;
   logic [c_REC_W-1:0]      r_rec_cnt;
   logic                    r_rd_err;

   logic        w_no_bus;
   logic        w_reg_wr;
   logic        w_wr_err;
   logic        w_last_beat;
   logic        w_drain;
   logic        w_timeout;
   logic        w_beat;
   logic        w_ca_hs;
   logic [31:0] w_wa_ext;
   logic [47:0] w_ca;
   logic        w_addr_unused;

   // Byte bit 0 and the address-space MSB are not part of the word address.
   assign w_addr_unused = ^{trans_address_i[ADDR_WIDTH-1], trans_address_i[0]};

   assign w_no_bus    = (r_cs == '0);
   assign w_reg_wr    = r_aspace & r_write;
   assign w_wr_err    = w_no_bus | (w_reg_wr & (r_burst != 8'd0));
   assign w_last_beat = (r_beat_cnt == {1'b0, r_burst});
   // Register writes only carry one word; extra beats are swallowed.
   assign w_drain     = w_no_bus | (w_reg_wr & (r_burst != 8'd0) & (r_beat_cnt != 9'd0));
   assign w_timeout   = (r_state == S_RDATA) & ~r_rd_err & ~phy_rx_valid_i &
                        (r_to_cnt == c_TO_W'(READ_TIMEOUT - 1));

   assign w_wa_ext = 32'(r_wa);
   assign w_ca     = {~r_write, r_aspace, r_btype, w_wa_ext[31:3], 13'd0, w_wa_ext[2:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= S_IDLE;
         r_wa       <= '0;
         r_cs       <= '0;
         r_write    <= 1'b0;
         r_burst    <= 8'd0;
         r_btype    <= 1'b0;
         r_aspace   <= 1'b0;
         r_ca_cnt   <= 2'd0;
         r_lat_cnt  <= '0;
         r_beat_cnt <= 9'd0;
         r_to_cnt   <= '0;
         r_rec_cnt  <= '0;
         r_rd_err   <= 1'b0;
      end else begin
         r_state <= w_next;

         if ((r_state == S_IDLE) && trans_valid_i) begin
            r_wa     <= trans_address_i[ADDR_WIDTH-2:1];
            r_cs     <= trans_cs_i;
            r_write  <= trans_write_i;
            r_burst  <= trans_burst_i;
            r_btype  <= trans_burst_type_i;
            r_aspace <= trans_address_space_i;
            // A read with no chip selected is answered entirely with error beats.
            r_rd_err <= (trans_cs_i == '0) & ~trans_write_i;
         end else if (w_timeout) begin
            r_rd_err <= 1'b1;
         end

         // Every per-state counter restarts whenever the state changes.
         if (w_next != r_state) begin
            r_ca_cnt   <= 2'd0;
            r_lat_cnt  <= '0;
            r_beat_cnt <= 9'd0;
            r_to_cnt   <= '0;
            r_rec_cnt  <= '0;
         end else begin
            if (w_ca_hs)
               r_ca_cnt <= r_ca_cnt + 2'd1;
            if ((r_state == S_LAT) && phy_word_ready_i)
               r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
            if (w_beat)
               r_beat_cnt <= r_beat_cnt + 9'd1;
            if ((r_state == S_RDATA) && !r_rd_err)
               r_to_cnt <= phy_rx_valid_i ? '0 : r_to_cnt + c_TO_W'(1);
            if (r_state == S_RECOV)
               r_rec_cnt <= r_rec_cnt + c_REC_W'(1);
         end
      end
   end

   always_comb begin
      w_next           = r_state;
      w_beat           = 1'b0;
      w_ca_hs          = 1'b0;
      trans_ready_o    = 1'b0;
      tx_ready_o       = 1'b0;
      rx_data_o        = 16'h0000;
      rx_last_o        = 1'b0;
      rx_error_o       = 1'b0;
      rx_valid_o       = 1'b0;
      b_valid_o        = 1'b0;
      b_last_o         = 1'b0;
      b_error_o        = 1'b0;
      phy_cs_no        = '1;
      phy_oe_o         = 1'b0;
      phy_word_o       = 16'h0000;
      phy_mask_o       = 2'b00;
      phy_word_valid_o = 1'b0;
      phy_rx_ready_o   = 1'b0;

      case (r_state)
         S_IDLE: begin
            trans_ready_o = 1'b1;
            if (trans_valid_i)
               w_next = S_CA;
         end

         S_CA: begin
            if (w_no_bus) begin
               w_next = r_write ? S_WDATA : S_RDATA;
            end else begin
               phy_cs_no        = ~r_cs;
               phy_oe_o         = 1'b1;
               phy_word_valid_o = 1'b1;
               case (r_ca_cnt)
                  2'd0:    phy_word_o = w_ca[47:32];
                  2'd1:    phy_word_o = w_ca[31:16];
                  default: phy_word_o = w_ca[15:0];
               endcase
               if (phy_word_ready_i) begin
                  w_ca_hs = 1'b1;
                  if (r_ca_cnt == 2'd2)
                     w_next = w_reg_wr ? S_WDATA : S_LAT;
               end
            end
         end

         S_LAT: begin
            phy_cs_no = ~r_cs;
            phy_oe_o  = r_write;
            if (phy_word_ready_i && (r_lat_cnt == c_LAT_W'(LATENCY_CYCLES - 1)))
               w_next = r_write ? S_WDATA : S_RDATA;
         end

         S_WDATA: begin
            phy_cs_no = ~r_cs;
            if (w_drain) begin
               tx_ready_o = 1'b1;
               w_beat     = tx_valid_i;
            end else begin
               phy_oe_o         = 1'b1;
               phy_word_o       = tx_data_i;
               phy_mask_o       = ~tx_strb_i;
               phy_word_valid_o = tx_valid_i;
               tx_ready_o       = phy_word_ready_i;
               w_beat           = tx_valid_i & phy_word_ready_i;
            end
            if (w_beat && w_last_beat)
               w_next = S_RESP;
         end

         S_RESP: begin
            b_valid_o = 1'b1;
            b_last_o  = 1'b1;
            b_error_o = w_wr_err;
            if (b_ready_i)
               w_next = S_RECOV;
         end

         S_RDATA: begin
            phy_rx_ready_o = rx_ready_i;
            if (r_rd_err) begin
               // Bus released; remaining beats are synthesised as errors.
               rx_valid_o = 1'b1;
               rx_error_o = 1'b1;
               rx_last_o  = w_last_beat;
               w_beat     = rx_ready_i;
            end else begin
               phy_cs_no  = ~r_cs;
               rx_data_o  = phy_rx_word_i;
               rx_valid_o = phy_rx_valid_i;
               rx_last_o  = phy_rx_valid_i & w_last_beat;
               w_beat     = phy_rx_valid_i & rx_ready_i;
            end
            if (w_beat && w_last_beat)
               w_next = S_RECOV;
         end

         S_RECOV: begin
            if (r_rec_cnt == c_REC_W'(CS_RECOVERY - 1))
               w_next = S_IDLE;
         end

         default: w_next = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_trans_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_hyperbus_trans_engine
// Description : Directed self-checking bench for hyperbus_trans_engine.
//               A table of transactions with hand-computed CA words,
//               latency, beat counts and error flags, plus hand-written
//               sequences for read timeout and reset mid-write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperbus_trans_engine;

   logic        clk_i;
   logic        rst_ni;
   logic        trans_valid_i;
   logic        trans_ready_o;
   logic [31:0] trans_address_i;
   logic [1:0]  trans_cs_i;
   logic        trans_write_i;
   logic [7:0]  trans_burst_i;
   logic        trans_burst_type_i;
   logic        trans_address_space_i;
   logic [15:0] tx_data_i;
   logic [1:0]  tx_strb_i;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic [15:0] rx_data_o;
   logic        rx_last_o;
   logic        rx_error_o;
   logic        rx_valid_o;
   logic        rx_ready_i;
   logic        b_valid_o;
   logic        b_ready_i;
   logic        b_last_o;
   logic        b_error_o;
   logic [1:0]  phy_cs_no;
   logic        phy_oe_o;
   logic [15:0] phy_word_o;
   logic [1:0]  phy_mask_o;
   logic        phy_word_valid_o;
   logic        phy_word_ready_i;
   logic [15:0] phy_rx_word_i;
   logic        phy_rx_valid_i;
   logic        phy_rx_ready_o;

   hyperbus_trans_engine u_dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .trans_valid_i         (trans_valid_i),
      .trans_ready_o         (trans_ready_o),
      .trans_address_i       (trans_address_i),
      .trans_cs_i            (trans_cs_i),
      .trans_write_i         (trans_write_i),
      .trans_burst_i         (trans_burst_i),
      .trans_burst_type_i    (trans_burst_type_i),
      .trans_address_space_i (trans_address_space_i),
      .tx_data_i             (tx_data_i),
      .tx_strb_i             (tx_strb_i),
      .tx_valid_i            (tx_valid_i),
      .tx_ready_o            (tx_ready_o),
      .rx_data_o             (rx_data_o),
      .rx_last_o             (rx_last_o),
      .rx_error_o            (rx_error_o),
      .rx_valid_o            (rx_valid_o),
      .rx_ready_i            (rx_ready_i),
      .b_valid_o             (b_valid_o),
      .b_ready_i             (b_ready_i),
      .b_last_o              (b_last_o),
      .b_error_o             (b_error_o),
      .phy_cs_no             (phy_cs_no),
      .phy_oe_o              (phy_oe_o),
      .phy_word_o            (phy_word_o),
      .phy_mask_o            (phy_mask_o),
      .phy_word_valid_o      (phy_word_valid_o),
      .phy_word_ready_i      (phy_word_ready_i),
      .phy_rx_word_i         (phy_rx_word_i),
      .phy_rx_valid_i        (phy_rx_valid_i),
      .phy_rx_ready_o        (phy_rx_ready_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // ndata: words forwarded to the PHY for writes, beats returned for reads.
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  cs;
      logic        wr;
      logic [7:0]  burst;
      logic        btype;
      logic        aspace;
      logic [1:0]  strb0;
      logic [15:0] ca0;
      logic [15:0] ca1;
      logic [15:0] ca2;
      logic [7:0]  lat;
      logic [8:0]  ndata;
      logic        err;
   } vec_t;

   vec_t vecs [9];
   vec_t v;
   int   n_cmp;
   int   n_err;
   int   silent, nerr, last_at;
   bit   csok, done, bseen;

   function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] cs,
                               input logic wr, input logic [7:0] burst,
                               input logic btype, input logic aspace,
                               input logic [1:0] strb0, input logic [15:0] ca0,
                               input logic [15:0] ca1, input logic [15:0] ca2,
                               input logic [7:0] lat, input logic [8:0] ndata,
                               input logic err);
      vec_t r;
      r.addr = addr; r.cs = cs; r.wr = wr; r.burst = burst; r.btype = btype;
      r.aspace = aspace; r.strb0 = strb0; r.ca0 = ca0; r.ca1 = ca1; r.ca2 = ca2;
      r.lat = lat; r.ndata = ndata; r.err = err;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_cmd(input vec_t tv);
      trans_valid_i         = 1'b1;
      trans_address_i       = tv.addr;
      trans_cs_i            = tv.cs;
      trans_write_i         = tv.wr;
      trans_burst_i         = tv.burst;
      trans_burst_type_i    = tv.btype;
      trans_address_space_i = tv.aspace;
      #1;
      check("cmd_ready", trans_ready_o, 1);
      @(negedge clk_i);
      trans_valid_i = 1'b0;
   endtask

   task automatic do_ca(input vec_t tv);
      logic [15:0] got [3];
      logic [1:0]  cs_exp;
      int          n;
      n      = 0;
      cs_exp = ~tv.cs;
      for (int c = 0; c < 12 && n < 3; c++) begin
         #1;
         if (phy_word_valid_o) begin
            if (n == 0) begin
               check("ca_cs", phy_cs_no, cs_exp);
               check("ca_oe", phy_oe_o, 1);
            end
            got[n] = phy_word_o;
            n++;
         end
         @(negedge clk_i);
      end
      check("ca_count", n, 3);
      check("ca_w0", got[0], tv.ca0);
      check("ca_w1", got[1], tv.ca1);
      check("ca_w2", got[2], tv.ca2);
   endtask

   task automatic do_lat(input vec_t tv);
      int lat;
      bit wv;
      lat = 0;
      wv  = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (tx_ready_o || phy_rx_ready_o || rx_valid_o) break;
         if (phy_word_valid_o) wv = 1;
         lat++;
         @(negedge clk_i);
      end
      check("lat_slots", lat, tv.lat);
      check("lat_novalid", wv, 0);
   endtask

   task automatic do_wdata(input vec_t tv);
      int         acc, fwd;
      logic [1:0] strb, mexp;
      logic [15:0] dexp;
      acc = 0;
      fwd = 0;
      for (int c = 0; c < 600 && acc <= int'(tv.burst); c++) begin
         strb       = (acc == 0) ? tv.strb0 : 2'b11;
         mexp       = ~strb;
         dexp       = 16'hD000 + 16'(acc);
         tx_valid_i = 1'b1;
         tx_data_i  = dexp;
         tx_strb_i  = strb;
         #1;
         if (phy_word_valid_o && phy_word_ready_i) begin
            fwd++;
            check("wr_word", phy_word_o, dexp);
            check("wr_mask", phy_mask_o, mexp);
         end
         if (tx_ready_o) acc++;
         @(negedge clk_i);
      end
      tx_valid_i = 1'b0;
      check("wr_beats", acc, tv.burst + 1);
      check("wr_fwd", fwd, tv.ndata);
   endtask

   task automatic do_resp(input vec_t tv);
      bit got;
      got       = 0;
      b_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (b_valid_o) begin
            check("b_error", b_error_o, tv.err);
            check("b_last", b_last_o, 1);
            got = 1;
            @(negedge clk_i);
            break;
         end
         @(negedge clk_i);
      end
      b_ready_i = 1'b0;
      check("b_seen", got, 1);
   endtask

   task automatic do_rdata(input vec_t tv);
      int          beats, lat_at;
      bit          fin;
      logic [15:0] dexp;
      beats  = 0;
      lat_at = -1;
      fin    = 0;
      for (int c = 0; c < 1000 && !fin; c++) begin
         phy_rx_valid_i = 1'b1;
         phy_rx_word_i  = 16'hC000 + 16'(beats);
         #1;
         if (rx_valid_o) begin
            dexp = tv.err ? 16'h0000 : 16'hC000 + 16'(beats);
            check("rd_data", rx_data_o, dexp);
            check("rd_err", rx_error_o, tv.err);
            if (rx_last_o) begin
               lat_at = beats;
               fin    = 1;
            end
            beats++;
         end
         @(negedge clk_i);
      end
      phy_rx_valid_i = 1'b0;
      check("rd_beats", beats, tv.ndata);
      check("rd_last_at", lat_at, tv.ndata - 1);
   endtask

   task automatic do_recov();
      int rec;
      bit csbad;
      rec   = 0;
      csbad = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (trans_ready_o) break;
         if (phy_cs_no !== 2'b11) csbad = 1;
         rec++;
         @(negedge clk_i);
      end
      check("recov_cycles", rec, 2);
      check("recov_cs_high", csbad, 0);
   endtask

   task automatic run_txn(input vec_t tv);
      do_cmd(tv);
      if (tv.cs != 2'b00) do_ca(tv);
      do_lat(tv);
      if (tv.wr) begin
         do_wdata(tv);
         do_resp(tv);
      end else begin
         do_rdata(tv);
      end
      do_recov();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_ni = 1'b0;
      trans_valid_i = 1'b0; trans_address_i = '0; trans_cs_i = '0;
      trans_write_i = 1'b0; trans_burst_i = '0; trans_burst_type_i = 1'b0;
      trans_address_space_i = 1'b0;
      tx_data_i = '0; tx_strb_i = '0; tx_valid_i = 1'b0;
      rx_ready_i = 1'b1; b_ready_i = 1'b0;
      phy_word_ready_i = 1'b1; phy_rx_word_i = '0; phy_rx_valid_i = 1'b0;

      //          addr           cs     wr burst btyp asp strb0  ca0       ca1       ca2       lat ndata err
      vecs[0] = mk(32'h0000_0010, 2'b01, 0, 8'd3,   1,  0, 2'b11, 16'hA000, 16'h0001, 16'h0000, 6, 4,   0);
      vecs[1] = mk(32'h0000_0020, 2'b01, 1, 8'd1,   1,  0, 2'b01, 16'h2000, 16'h0002, 16'h0000, 6, 2,   0);
      vecs[2] = mk(32'h0000_0004, 2'b10, 1, 8'd0,   0,  1, 2'b11, 16'h4000, 16'h0000, 16'h0002, 0, 1,   0);
      vecs[3] = mk(32'h0000_0000, 2'b01, 1, 8'd2,   1,  1, 2'b11, 16'h6000, 16'h0000, 16'h0000, 0, 1,   1);
      vecs[4] = mk(32'h8000_1236, 2'b10, 0, 8'd0,   0,  1, 2'b11, 16'hC000, 16'h0123, 16'h0003, 6, 1,   0);
      vecs[5] = mk(32'h7FFF_FFFE, 2'b01, 1, 8'd0,   1,  0, 2'b10, 16'h27FF, 16'hFFFF, 16'h0007, 6, 1,   0);
      vecs[6] = mk(32'h0000_0040, 2'b00, 1, 8'd2,   1,  0, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1, 0,   1);
      vecs[7] = mk(32'h0000_0040, 2'b00, 0, 8'd1,   1,  0, 2'b11, 16'h0000, 16'h0000, 16'h0000, 1, 2,   1);
      vecs[8] = mk(32'h0000_0000, 2'b01, 0, 8'd255, 1,  0, 2'b11, 16'hA000, 16'h0000, 16'h0000, 6, 256, 1'b0);

      repeat (3) @(negedge clk_i);
      #1;
      check("rst_trans_ready", trans_ready_o, 1);
      check("rst_cs_n", phy_cs_no, 2'b11);
      check("rst_word_valid", phy_word_valid_o, 0);
      check("rst_oe", phy_oe_o, 0);
      check("rst_tx_ready", tx_ready_o, 0);
      check("rst_rx_valid", rx_valid_o, 0);
      check("rst_b_valid", b_valid_o, 0);
      check("rst_rx_ready", phy_rx_ready_o, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);

      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // Read that stalls after its first beat until the timeout fires.
      v = mk(32'h0, 2'b01, 0, 8'd3, 1, 0, 2'b11, 16'hA000, 16'h0000, 16'h0000, 6, 4, 1);
      do_cmd(v);
      do_ca(v);
      do_lat(v);
      phy_rx_valid_i = 1'b1;
      phy_rx_word_i  = 16'h1111;
      #1;
      check("to_beat1_valid", rx_valid_o, 1);
      check("to_beat1_data", rx_data_o, 16'h1111);
      @(negedge clk_i);
      phy_rx_valid_i = 1'b0;
      silent = 0;
      csok   = 1;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (rx_valid_o) break;
         if (phy_cs_no !== 2'b10) csok = 0;
         silent++;
         @(negedge clk_i);
      end
      check("to_silent", silent, 64);
      check("to_cs_held", csok, 1);
      nerr    = 0;
      last_at = -1;
      done    = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (rx_valid_o) begin
            check("to_err", rx_error_o, 1);
            check("to_data", rx_data_o, 0);
            check("to_cs_rel", phy_cs_no, 2'b11);
            if (rx_last_o) begin
               last_at = nerr;
               done    = 1;
            end
            nerr++;
         end
         @(negedge clk_i);
         #1;
      end
      check("to_nerr", nerr, 3);
      check("to_last_at", last_at, 2);
      do_recov();

      // Reset pulse in the middle of a write burst.
      v = mk(32'h20, 2'b01, 1, 8'd3, 1, 0, 2'b11, 16'h2000, 16'h0002, 16'h0000, 6, 4, 0);
      do_cmd(v);
      do_ca(v);
      do_lat(v);
      tx_valid_i = 1'b1;
      tx_data_i  = 16'hBEEF;
      tx_strb_i  = 2'b11;
      #1;
      check("rst_pre_valid", phy_word_valid_o, 1);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("rst_mid_cs", phy_cs_no, 2'b11);
      check("rst_mid_ready", trans_ready_o, 1);
      check("rst_mid_wvalid", phy_word_valid_o, 0);
      tx_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      bseen = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (b_valid_o) bseen = 1;
         @(negedge clk_i);
      end
      check("rst_no_b", bseen, 0);
      run_txn(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
